// File: rtl/ulpi_link_pkg.sv
// Shared definitions for the ULPI link controller: state codes, TXCMD prefixes and bus constants.
package ulpi_link_pkg;

  typedef enum logic [3:0] {
    StInit      = 4'd0,
    StIdle      = 4'd1,
    StTaIn      = 4'd2,
    StRecv      = 4'd3,
    StTaOut     = 4'd4,
    StRegLatch  = 4'd5,
    StRegCmd    = 4'd6,
    StRegCmdAck = 4'd7,
    StRegWdata  = 4'd8,
    StRegStp    = 4'd9,
    StRegrCmd   = 4'd10,
    StRegrTa    = 4'd11,
    StRegrData  = 4'd12,
    StTxCmd     = 4'd13,
    StTxData    = 4'd14,
    StTxStp     = 4'd15
  } state_e;

  localparam logic [1:0] TxcmdRegw = 2'b10;
  localparam logic [1:0] TxcmdRegr = 2'b11;
  localparam logic [3:0] TxcmdTx   = 4'b0100;
  localparam logic [7:0] Noop      = 8'h00;

  // RX CMD RxEvent field 2'b11 flags an RX error from the PHY.
  function automatic logic is_rx_err(input logic [7:0] rxcmd);
    return rxcmd[5:4] == 2'b11;
  endfunction

endpackage

// File: rtl/ulpi_link_if.sv
// Device-side register and packet-stream bundle of the ULPI link controller.
interface ulpi_link_if;
  logic       REG_EN;
  logic       REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I;
  logic [7:0] REG_DATA_O;
  logic       REG_DONE;
  logic       REG_FAIL;
  logic [7:0] RXCMD;
  logic       READY;
  logic [7:0] USB_DATA_IN;
  logic       USB_DATA_IN_START_END;
  logic       USB_DATA_IN_STRB;
  logic       USB_DATA_IN_FAIL;
  logic [7:0] USB_DATA_OUT;
  logic       USB_DATA_OUT_STRB;
  logic       USB_DATA_OUT_END;
  logic       USB_DATA_OUT_FAIL;

  modport master (
    output REG_EN, REG_RW, REG_ADDR, REG_DATA_I, USB_DATA_IN, USB_DATA_IN_START_END,
    input  REG_DATA_O, REG_DONE, REG_FAIL, RXCMD, READY, USB_DATA_IN_STRB, USB_DATA_IN_FAIL,
    input  USB_DATA_OUT, USB_DATA_OUT_STRB, USB_DATA_OUT_END, USB_DATA_OUT_FAIL
  );

  modport slave (
    input  REG_EN, REG_RW, REG_ADDR, REG_DATA_I, USB_DATA_IN, USB_DATA_IN_START_END,
    output REG_DATA_O, REG_DONE, REG_FAIL, RXCMD, READY, USB_DATA_IN_STRB, USB_DATA_IN_FAIL,
    output USB_DATA_OUT, USB_DATA_OUT_STRB, USB_DATA_OUT_END, USB_DATA_OUT_FAIL
  );
endinterface

// File: rtl/ulpi_link.sv
// Link-side ULPI controller: PHY reset release, RX CMD/packet receive, register access, packet TX.
module ulpi_link
  import ulpi_link_pkg::*;
(
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  inout  wire  [7:0] USB_DATA,
  input  logic       USB_DIR,
  input  logic       USB_NXT,
  output logic       USB_STP,
  output logic       USB_RESETN,
  output logic       USB_CS,
  output logic [7:0] STATE,
  ulpi_link_if.slave dev
);

  state_e     state_q, state_d;
  logic       resetn_q;
  logic       rw_q, rw_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] pid_q, pid_d;
  logic [7:0] rxcmd_q, rxcmd_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] dout_q, dout_d;
  logic       rx_pkt_q, rx_pkt_d;
  logic       dout_strb_q, dout_strb_d;
  logic       dout_end_q, dout_end_d;
  logic       dout_fail_q, dout_fail_d;
  logic       reg_done_q, reg_done_d;
  logic       reg_fail_q, reg_fail_d;
  logic       din_fail_q, din_fail_d;
  logic       link_oe;
  logic [7:0] bus_out;

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q     <= StInit;
      resetn_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pid_q       <= '0;
      rxcmd_q     <= '0;
      rdata_q     <= '0;
      dout_q      <= '0;
      rx_pkt_q    <= 1'b0;
      dout_strb_q <= 1'b0;
      dout_end_q  <= 1'b0;
      dout_fail_q <= 1'b0;
      reg_done_q  <= 1'b0;
      reg_fail_q  <= 1'b0;
      din_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resetn_q    <= 1'b1;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pid_q       <= pid_d;
      rxcmd_q     <= rxcmd_d;
      rdata_q     <= rdata_d;
      dout_q      <= dout_d;
      rx_pkt_q    <= rx_pkt_d;
      dout_strb_q <= dout_strb_d;
      dout_end_q  <= dout_end_d;
      dout_fail_q <= dout_fail_d;
      reg_done_q  <= reg_done_d;
      reg_fail_q  <= reg_fail_d;
      din_fail_q  <= din_fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pid_d       = pid_q;
    rxcmd_d     = rxcmd_q;
    rdata_d     = rdata_q;
    dout_d      = dout_q;
    rx_pkt_d    = rx_pkt_q;
    dout_strb_d = 1'b0;
    dout_end_d  = 1'b0;
    dout_fail_d = 1'b0;
    reg_done_d  = 1'b0;
    reg_fail_d  = 1'b0;
    din_fail_d  = 1'b0;
    case (state_q)
      // Hold one edge after reset so the PHY sees RESETN high before we leave INIT.
      StInit: if (resetn_q && !USB_DIR) state_d = StIdle;
      StIdle: begin
        if (USB_DIR) begin
          state_d = StTaIn;
        end else if (dev.REG_EN) begin
          rw_d    = dev.REG_RW;
          addr_d  = dev.REG_ADDR;
          wdata_d = dev.REG_DATA_I;
          state_d = StRegLatch;
        end else if (dev.USB_DATA_IN_START_END) begin
          pid_d   = dev.USB_DATA_IN[3:0];
          state_d = StTxCmd;
        end
      end
      StTaIn, StRecv: begin
        if (USB_DIR) begin
          if (!USB_NXT) begin
            rxcmd_d     = USB_DATA;
            dout_fail_d = rx_pkt_q && is_rx_err(USB_DATA);
          end else begin
            dout_d      = USB_DATA;
            dout_strb_d = 1'b1;
            rx_pkt_d    = 1'b1;
          end
          state_d = StRecv;
        end else begin
          dout_end_d = (state_q == StRecv) && rx_pkt_q;
          rx_pkt_d   = 1'b0;
          state_d    = (state_q == StRecv) ? StTaOut : StIdle;
        end
      end
      StTaOut:    state_d = StIdle;
      StRegLatch: state_d = rw_q ? StRegCmd : StRegrCmd;
      StRegCmd, StRegCmdAck, StRegWdata, StRegStp: begin
        if (USB_DIR) begin
          reg_fail_d = 1'b1;
          state_d    = StTaIn;
        end else begin
          unique case (state_q)
            StRegCmd:    if (USB_NXT) state_d = StRegCmdAck;
            StRegCmdAck: if (USB_NXT) state_d = StRegWdata;
            StRegWdata: begin
              if (!USB_NXT) begin
                reg_done_d = 1'b1;
                state_d    = StRegStp;
              end
            end
            default:     state_d = StIdle;
          endcase
        end
      end
      StRegrCmd: begin
        if (USB_DIR && USB_NXT) begin
          reg_fail_d = 1'b1;
          state_d    = StTaIn;
        end else if (!USB_DIR && USB_NXT) begin
          state_d = StRegrTa;
        end
      end
      StRegrTa, StRegrData: begin
        if (!USB_DIR) begin
          reg_fail_d = 1'b1;
          state_d    = StIdle;
        end else if (state_q == StRegrTa) begin
          state_d = StRegrData;
        end else begin
          rdata_d    = USB_DATA;
          reg_done_d = 1'b1;
          state_d    = StTaOut;
        end
      end
      StTxCmd, StTxData: begin
        if (USB_DIR) begin
          din_fail_d = 1'b1;
          state_d    = StTaIn;
        end else if (state_q == StTxCmd) begin
          if (USB_NXT) state_d = StTxData;
        end else if (dev.USB_DATA_IN_START_END) begin
          state_d = StTxStp;
        end
      end
      StTxStp:    state_d = StIdle;
      default:    state_d = StInit;
    endcase
  end

  always_comb begin
    link_oe = 1'b0;
    bus_out = Noop;
    case (state_q)
      StIdle, StRegLatch, StRegStp, StTxStp: link_oe = 1'b1;
      StRegCmd, StRegCmdAck: begin
        link_oe = 1'b1;
        bus_out = {TxcmdRegw, addr_q};
      end
      StRegWdata: begin
        link_oe = 1'b1;
        bus_out = wdata_q;
      end
      StRegrCmd: begin
        link_oe = 1'b1;
        bus_out = {TxcmdRegr, addr_q};
      end
      StTxCmd: begin
        link_oe = 1'b1;
        bus_out = {TxcmdTx, pid_q};
      end
      StTxData: begin
        link_oe = 1'b1;
        bus_out = dev.USB_DATA_IN;
      end
      default: link_oe = 1'b0;
    endcase
  end

  // The PHY owns the bus whenever DIR is high, regardless of our state.
  assign USB_DATA   = (link_oe && !USB_DIR) ? bus_out : 8'hzz;
  assign USB_STP    = (state_q == StInit) || (state_q == StRegStp) || (state_q == StTxStp);
  assign USB_RESETN = resetn_q;
  assign USB_CS     = 1'b1;
  assign STATE      = {4'h0, state_q};

  assign dev.READY             = (state_q == StIdle);
  assign dev.RXCMD             = rxcmd_q;
  assign dev.REG_DATA_O        = rdata_q;
  assign dev.REG_DONE          = reg_done_q;
  assign dev.REG_FAIL          = reg_fail_q;
  assign dev.USB_DATA_IN_STRB  = (state_q == StTxData) && !USB_DIR && USB_NXT;
  assign dev.USB_DATA_IN_FAIL  = din_fail_q;
  assign dev.USB_DATA_OUT      = dout_q;
  assign dev.USB_DATA_OUT_STRB = dout_strb_q;
  assign dev.USB_DATA_OUT_END  = dout_end_q;
  assign dev.USB_DATA_OUT_FAIL = dout_fail_q;

endmodule

// File: tb/tb_ulpi_link.sv
// Directed self-checking bench for ulpi_link with a simple scripted PHY on the ULPI bus.
module tb_ulpi_link;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       usb_dir = 1'b0;
  logic       usb_nxt = 1'b0;
  logic [7:0] phy_val = 8'h00;
  wire  [7:0] usb_data;
  logic       usb_stp, usb_resetn, usb_cs;
  logic [7:0] state;
  int         checks = 0;
  int         errors = 0;

  ulpi_link_if dev_if ();

  assign usb_data = usb_dir ? phy_val : 8'hzz;

  ulpi_link dut (
    .CLK_60M    (clk),
    .NRST_A_USB (rst_n),
    .USB_DATA   (usb_data),
    .USB_DIR    (usb_dir),
    .USB_NXT    (usb_nxt),
    .USB_STP    (usb_stp),
    .USB_RESETN (usb_resetn),
    .USB_CS     (usb_cs),
    .STATE      (state),
    .dev        (dev_if)
  );

  always #8 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++; if (usb_resetn !== 1'b0) begin errors++; $display("FAIL rst_resetn: got %b want 0", usb_resetn); end
    checks++; if (usb_stp !== 1'b1) begin errors++; $display("FAIL rst_stp: got %b want 1", usb_stp); end
    checks++; if (state !== 8'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (dev_if.READY !== 1'b0 || dev_if.REG_DONE !== 1'b0 || dev_if.REG_FAIL !== 1'b0)
      begin errors++; $display("FAIL rst_flags: got rdy=%b done=%b fail=%b want 0", dev_if.READY,
                               dev_if.REG_DONE, dev_if.REG_FAIL); end
    checks++; if (dev_if.RXCMD !== 8'h00 || dev_if.REG_DATA_O !== 8'h00 || dev_if.USB_DATA_OUT !== 8'h00)
      begin errors++; $display("FAIL rst_data: got %h/%h/%h want 00", dev_if.RXCMD, dev_if.REG_DATA_O,
                               dev_if.USB_DATA_OUT); end
    checks++; if (usb_cs !== 1'b1) begin errors++; $display("FAIL cs: got %b want 1", usb_cs); end
    rst_n = 1'b1;
    tick();
    checks++; if (state !== 8'd0 || usb_resetn !== 1'b1)
      begin errors++; $display("FAIL init_hold: got st=%0d resetn=%b want 0/1", state, usb_resetn); end
    tick();
    checks++; if (dev_if.READY !== 1'b1 || state !== 8'd1)
      begin errors++; $display("FAIL ready: got rdy=%b st=%0d want 1/1", dev_if.READY, state); end
    checks++; if (usb_data !== 8'h00) begin errors++; $display("FAIL idle_noop: got %h want 00", usb_data); end
  endtask

  task automatic test_rxcmd;
    usb_dir = 1'b1;
    phy_val = 8'h00;
    tick();
    checks++; if (state !== 8'd2) begin errors++; $display("FAIL rx_ta_in: got %0d want 2", state); end
    for (int i = 1; i <= 10; i++) begin
      phy_val = 8'(i);
      tick();
      checks++; if (dev_if.RXCMD !== 8'(i))
        begin errors++; $display("FAIL rxcmd_%0d: got %h want %h", i, dev_if.RXCMD, 8'(i)); end
    end
    usb_dir = 1'b0;
    tick();
    checks++; if (state !== 8'd4 || dev_if.USB_DATA_OUT_END !== 1'b0)
      begin errors++; $display("FAIL rx_ta_out: got st=%0d end=%b want 4/0", state,
                               dev_if.USB_DATA_OUT_END); end
    tick();
    checks++; if (dev_if.READY !== 1'b1) begin errors++; $display("FAIL rx_idle: got %b want 1", dev_if.READY); end
  endtask

  task automatic test_rx_packet;
    usb_dir = 1'b1;
    tick();
    phy_val = 8'h4C;
    tick();
    usb_nxt = 1'b1;
    phy_val = 8'hA5;
    tick();
    checks++; if (dev_if.USB_DATA_OUT !== 8'hA5 || dev_if.USB_DATA_OUT_STRB !== 1'b1)
      begin errors++; $display("FAIL rx_byte: got %h strb=%b want a5/1", dev_if.USB_DATA_OUT,
                               dev_if.USB_DATA_OUT_STRB); end
    usb_nxt = 1'b0;
    phy_val = 8'h30;
    tick();
    checks++; if (dev_if.USB_DATA_OUT_FAIL !== 1'b1 || dev_if.RXCMD !== 8'h30 || dev_if.USB_DATA_OUT_STRB !== 1'b0)
      begin errors++; $display("FAIL rx_err: got fail=%b rxcmd=%h strb=%b want 1/30/0",
                               dev_if.USB_DATA_OUT_FAIL, dev_if.RXCMD, dev_if.USB_DATA_OUT_STRB); end
    usb_dir = 1'b0;
    tick();
    checks++; if (dev_if.USB_DATA_OUT_END !== 1'b1 || state !== 8'd4)
      begin errors++; $display("FAIL rx_end: got end=%b st=%0d want 1/4", dev_if.USB_DATA_OUT_END, state); end
    tick();
  endtask

  task automatic test_reg_write;
    dev_if.REG_EN = 1'b1; dev_if.REG_RW = 1'b1; dev_if.REG_ADDR = 6'h07; dev_if.REG_DATA_I = 8'h07;
    tick();
    dev_if.REG_EN = 1'b0;
    usb_nxt = 1'b1;
    checks++; if (state !== 8'd5) begin errors++; $display("FAIL wr_latch: got %0d want 5", state); end
    tick();
    checks++; if (usb_data !== 8'h87) begin errors++; $display("FAIL wr_cmd: got %h want 87", usb_data); end
    tick();
    checks++; if (usb_data !== 8'h87 || state !== 8'd7)
      begin errors++; $display("FAIL wr_cmd_ack: got %h st=%0d want 87/7", usb_data, state); end
    tick();
    checks++; if (usb_data !== 8'h07) begin errors++; $display("FAIL wr_data: got %h want 07", usb_data); end
    usb_nxt = 1'b0;
    tick();
    checks++; if (usb_stp !== 1'b1 || dev_if.REG_DONE !== 1'b1 || dev_if.REG_FAIL !== 1'b0)
      begin errors++; $display("FAIL wr_stp: got stp=%b done=%b fail=%b want 1/1/0", usb_stp,
                               dev_if.REG_DONE, dev_if.REG_FAIL); end
    tick();
    checks++; if (dev_if.READY !== 1'b1 || dev_if.REG_DONE !== 1'b0 || usb_stp !== 1'b0)
      begin errors++; $display("FAIL wr_idle: got rdy=%b done=%b stp=%b want 1/0/0", dev_if.READY,
                               dev_if.REG_DONE, usb_stp); end
  endtask

  task automatic test_write_abort;
    dev_if.REG_EN = 1'b1; dev_if.REG_RW = 1'b1; dev_if.REG_ADDR = 6'h2A; dev_if.REG_DATA_I = 8'h3C;
    tick();
    dev_if.REG_EN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k >= 1) begin usb_nxt = 1'b1; tick(); end
      if (k >= 2) tick();
      if (k >= 3) begin usb_nxt = 1'b0; tick(); end
      usb_nxt = 1'b0;
      checks++; if (state !== 8'(6 + k))
        begin errors++; $display("FAIL ab_pre_%0d: got %0d want %0d", k, state, 6 + k); end
      usb_dir = 1'b1;
      tick();
      checks++; if (dev_if.REG_FAIL !== 1'b1 || usb_stp !== 1'b0 || state !== 8'd2)
        begin errors++; $display("FAIL abort_%0d: got fail=%b stp=%b st=%0d want 1/0/2", k,
                                 dev_if.REG_FAIL, usb_stp, state); end
      usb_dir = 1'b0;
      tick();
      checks++; if (dev_if.READY !== 1'b1 || dev_if.REG_FAIL !== 1'b0)
        begin errors++; $display("FAIL ab_idle_%0d: got rdy=%b fail=%b want 1/0", k, dev_if.READY,
                                 dev_if.REG_FAIL); end
      dev_if.REG_EN = 1'b1;
      tick();
      dev_if.REG_EN = 1'b0;
      checks++; if (state !== 8'd5) begin errors++; $display("FAIL ab_accept_%0d: got %0d want 5", k, state); end
    end
    tick();
    usb_dir = 1'b1;
    tick();
    usb_dir = 1'b0;
    tick();
  endtask

  task automatic test_reg_read;
    dev_if.REG_EN = 1'b1; dev_if.REG_RW = 1'b0; dev_if.REG_ADDR = 6'h16;
    tick();
    dev_if.REG_EN = 1'b0;
    tick();
    checks++; if (usb_data !== 8'hD6 || state !== 8'd10)
      begin errors++; $display("FAIL rd_cmd: got %h st=%0d want d6/10", usb_data, state); end
    usb_nxt = 1'b1;
    tick();
    usb_nxt = 1'b0;
    usb_dir = 1'b1;
    phy_val = 8'h00;
    tick();
    phy_val = 8'h5A;
    tick();
    checks++; if (dev_if.REG_DATA_O !== 8'h5A || dev_if.REG_DONE !== 1'b1 || dev_if.REG_FAIL !== 1'b0)
      begin errors++; $display("FAIL rd_data: got %h done=%b fail=%b want 5a/1/0", dev_if.REG_DATA_O,
                               dev_if.REG_DONE, dev_if.REG_FAIL); end
    usb_dir = 1'b0;
    tick();
    checks++; if (dev_if.READY !== 1'b1) begin errors++; $display("FAIL rd_idle: got %b want 1", dev_if.READY); end
  endtask

  task automatic test_tx;
    dev_if.USB_DATA_IN = 8'h03;
    dev_if.USB_DATA_IN_START_END = 1'b1;
    tick();
    dev_if.USB_DATA_IN_START_END = 1'b0;
    checks++; if (usb_data !== 8'h43) begin errors++; $display("FAIL tx_cmd: got %h want 43", usb_data); end
    usb_nxt = 1'b1;
    tick();
    dev_if.USB_DATA_IN = 8'h11;
    #1;
    checks++; if (usb_data !== 8'h11 || dev_if.USB_DATA_IN_STRB !== 1'b1)
      begin errors++; $display("FAIL tx_b0: got %h strb=%b want 11/1", usb_data, dev_if.USB_DATA_IN_STRB); end
    tick();
    dev_if.USB_DATA_IN = 8'h22;
    #1;
    checks++; if (usb_data !== 8'h22 || dev_if.USB_DATA_IN_STRB !== 1'b1)
      begin errors++; $display("FAIL tx_b1: got %h strb=%b want 22/1", usb_data, dev_if.USB_DATA_IN_STRB); end
    usb_nxt = 1'b0;
    dev_if.USB_DATA_IN_START_END = 1'b1;
    tick();
    dev_if.USB_DATA_IN_START_END = 1'b0;
    checks++; if (usb_stp !== 1'b1 || state !== 8'd15)
      begin errors++; $display("FAIL tx_stp: got stp=%b st=%0d want 1/15", usb_stp, state); end
    tick();
    checks++; if (dev_if.READY !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b want 1", dev_if.READY); end
  endtask

  task automatic test_tx_abort;
    dev_if.USB_DATA_IN = 8'h05;
    dev_if.USB_DATA_IN_START_END = 1'b1;
    tick();
    dev_if.USB_DATA_IN_START_END = 1'b0;
    usb_nxt = 1'b1;
    tick();
    usb_nxt = 1'b0;
    usb_dir = 1'b1;
    tick();
    checks++; if (dev_if.USB_DATA_IN_FAIL !== 1'b1 || state !== 8'd2)
      begin errors++; $display("FAIL tx_abort: got fail=%b st=%0d want 1/2", dev_if.USB_DATA_IN_FAIL, state); end
    usb_dir = 1'b0;
    tick();
  endtask

  initial begin
    dev_if.REG_EN = 1'b0;
    dev_if.REG_RW = 1'b0;
    dev_if.REG_ADDR = '0;
    dev_if.REG_DATA_I = '0;
    dev_if.USB_DATA_IN = '0;
    dev_if.USB_DATA_IN_START_END = 1'b0;
    test_reset();
    test_rxcmd();
    test_rx_packet();
    test_reg_write();
    test_write_abort();
    test_reg_read();
    test_tx();
    test_tx_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
